// File: rtl/tilelink_n_to_1.sv
// N-master to 1-slave TileLink arbiter: round-robin A merge with burst lock, D steered by source MSBs.
// Optional macro TL_NTO1_DREG_EN inserts a 2-entry skid buffer ahead of D steering.
module tilelink_n_to_1 #(
  parameter int TLM   = 2,
  parameter int TL_AW = 32,
  parameter int TL_RS = 2,
  parameter int TL_DW = 5,
  parameter int TL_SZ = 4,
  localparam int MIDW = $clog2(TLM),
  localparam int SRW  = TL_RS + MIDW,
  localparam int DW   = 2**TL_DW,
  localparam int MW   = DW/8
) (
  input  logic                  tilelink_clock_i,
  input  logic                  tilelink_reset_i,
  input  logic [3*TLM-1:0]      master_a_opcode,
  input  logic [3*TLM-1:0]      master_a_param,
  input  logic [TL_SZ*TLM-1:0]  master_a_size,
  input  logic [TL_RS*TLM-1:0]  master_a_source,
  input  logic [TL_AW*TLM-1:0]  master_a_address,
  input  logic [TLM*MW-1:0]     master_a_mask,
  input  logic [TLM*DW-1:0]     master_a_data,
  input  logic [TLM-1:0]        master_a_corrupt,
  input  logic [TLM-1:0]        master_a_valid,
  output logic [TLM-1:0]        master_a_ready,
  output logic [3*TLM-1:0]      master_d_opcode,
  output logic [2*TLM-1:0]      master_d_param,
  output logic [TL_SZ*TLM-1:0]  master_d_size,
  output logic [TL_RS*TLM-1:0]  master_d_source,
  output logic [TLM-1:0]        master_d_denied,
  output logic [TLM-1:0]        master_d_corrupt,
  output logic [TLM-1:0]        master_d_valid,
  output logic [TLM*DW-1:0]     master_d_data,
  input  logic [TLM-1:0]        master_d_ready,
  output logic [2:0]            slave_a_opcode,
  output logic [2:0]            slave_a_param,
  output logic [TL_SZ-1:0]      slave_a_size,
  output logic [SRW-1:0]        slave_a_source,
  output logic [TL_AW-1:0]      slave_a_address,
  output logic [MW-1:0]         slave_a_mask,
  output logic [DW-1:0]         slave_a_data,
  output logic                  slave_a_corrupt,
  output logic                  slave_a_valid,
  input  logic                  slave_a_ready,
  input  logic [2:0]            slave_d_opcode,
  input  logic [1:0]            slave_d_param,
  input  logic [TL_SZ-1:0]      slave_d_size,
  input  logic [SRW-1:0]        slave_d_source,
  input  logic                  slave_d_denied,
  input  logic                  slave_d_corrupt,
  input  logic                  slave_d_valid,
  input  logic [DW-1:0]         slave_d_data,
  output logic                  slave_d_ready
);
  localparam int CW  = 2**TL_SZ;
  localparam int DPW = 3 + 2 + TL_SZ + SRW + 1 + 1 + DW;

  logic [MIDW-1:0] r_ptr, r_lock_mid, w_gnt, w_nxt;
  logic            r_lock, w_gnt_vld, w_ld, w_hs, w_multi;
  logic [CW-1:0]   r_cnt, w_bm1;
  logic [2:0]      w_op;
  logic [TL_SZ-1:0] w_sz;

  // Lowest offset from the pointer wins, so scan downward and let the last hit stick.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    if (r_lock) begin
      w_gnt_vld = master_a_valid[r_lock_mid];
      w_gnt     = r_lock_mid;
    end else begin
      for (int k = TLM-1; k >= 0; k--) begin
        if (master_a_valid[(int'(r_ptr) + k) % TLM]) begin
          w_gnt_vld = 1'b1;
          w_gnt     = MIDW'((int'(r_ptr) + k) % TLM);
        end
      end
    end
  end

  assign w_ld    = !slave_a_valid | slave_a_ready;
  assign w_hs    = w_ld & w_gnt_vld;
  assign w_op    = master_a_opcode[w_gnt*3 +: 3];
  assign w_sz    = master_a_size[w_gnt*TL_SZ +: TL_SZ];
  assign w_multi = (w_op == 3'd0 || w_op == 3'd1) && (int'(w_sz) > TL_DW-3);
  assign w_bm1   = (CW'(1) << (int'(w_sz) - (TL_DW-3))) - CW'(1);
  assign w_nxt   = (w_gnt == MIDW'(TLM-1)) ? '0 : w_gnt + 1'b1;

  always_ff @(posedge tilelink_clock_i or posedge tilelink_reset_i) begin
    if (tilelink_reset_i) begin
      slave_a_valid   <= 1'b0;
      slave_a_opcode  <= '0;
      slave_a_param   <= '0;
      slave_a_size    <= '0;
      slave_a_source  <= '0;
      slave_a_address <= '0;
      slave_a_mask    <= '0;
      slave_a_data    <= '0;
      slave_a_corrupt <= 1'b0;
      r_ptr           <= '0;
      r_lock          <= 1'b0;
      r_lock_mid      <= '0;
      r_cnt           <= '0;
    end else begin
      if (w_ld) slave_a_valid <= w_hs;
      if (w_hs) begin
        slave_a_opcode  <= w_op;
        slave_a_param   <= master_a_param[w_gnt*3 +: 3];
        slave_a_size    <= w_sz;
        slave_a_source  <= {w_gnt, master_a_source[w_gnt*TL_RS +: TL_RS]};
        slave_a_address <= master_a_address[w_gnt*TL_AW +: TL_AW];
        slave_a_mask    <= master_a_mask[w_gnt*MW +: MW];
        slave_a_data    <= master_a_data[w_gnt*DW +: DW];
        slave_a_corrupt <= master_a_corrupt[w_gnt];
        if (r_lock) begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) begin
            r_lock <= 1'b0;
            r_ptr  <= w_nxt;
          end
        end else if (w_multi) begin
          r_lock     <= 1'b1;
          r_lock_mid <= w_gnt;
          r_cnt      <= w_bm1;
        end else begin
          r_ptr <= w_nxt;
        end
      end
    end
  end

  logic [DPW-1:0]  w_din, w_dpl;
  logic            w_dv, w_dacc;
  logic [2:0]      w_dop;
  logic [1:0]      w_dpa;
  logic [TL_SZ-1:0] w_dsz;
  logic [SRW-1:0]  w_dsrc;
  logic            w_dden, w_dcor;
  logic [DW-1:0]   w_ddat;
  logic [MIDW-1:0] w_didx;

  assign w_din = {slave_d_opcode, slave_d_param, slave_d_size, slave_d_source,
                  slave_d_denied, slave_d_corrupt, slave_d_data};

`ifdef TL_NTO1_DREG_EN
  logic [DPW-1:0] r_dq [2];
  logic [1:0]     r_dcnt;
  logic           r_dwp, r_drp, w_push, w_pop;

  assign w_push        = slave_d_valid & (r_dcnt != 2'd2);
  assign w_pop         = w_dv & w_dacc;
  assign w_dv          = (r_dcnt != 2'd0);
  assign w_dpl         = r_dq[r_drp];
  assign slave_d_ready = (r_dcnt != 2'd2);

  always_ff @(posedge tilelink_clock_i or posedge tilelink_reset_i) begin
    if (tilelink_reset_i) begin
      r_dcnt <= '0;
      r_dwp  <= 1'b0;
      r_drp  <= 1'b0;
    end else begin
      if (w_push) r_dwp <= ~r_dwp;
      if (w_pop)  r_drp <= ~r_drp;
      r_dcnt <= r_dcnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  always_ff @(posedge tilelink_clock_i) begin
    if (w_push) r_dq[r_dwp] <= w_din;
  end
`else
  assign w_dv          = slave_d_valid;
  assign w_dpl         = w_din;
  assign slave_d_ready = w_dacc;
`endif

  assign {w_dop, w_dpa, w_dsz, w_dsrc, w_dden, w_dcor, w_ddat} = w_dpl;
  assign w_didx = w_dsrc[SRW-1:TL_RS];

  // Indices with no master behind them are sunk so a stray response cannot stall D.
  always_comb begin
    w_dacc = 1'b1;
    for (int i = 0; i < TLM; i++)
      if (w_didx == MIDW'(i)) w_dacc = master_d_ready[i];
  end

  for (genvar i = 0; i < TLM; i++) begin : g_m
    assign master_a_ready[i]              = w_ld & w_gnt_vld & (w_gnt == MIDW'(i)) & !tilelink_reset_i;
    assign master_d_valid[i]              = w_dv & (w_didx == MIDW'(i));
    assign master_d_opcode[i*3 +: 3]      = w_dop;
    assign master_d_param[i*2 +: 2]       = w_dpa;
    assign master_d_size[i*TL_SZ +: TL_SZ] = w_dsz;
    assign master_d_source[i*TL_RS +: TL_RS] = w_dsrc[TL_RS-1:0];
    assign master_d_denied[i]             = w_dden;
    assign master_d_corrupt[i]            = w_dcor;
    assign master_d_data[i*DW +: DW]      = w_ddat;
  end
endmodule

// File: tb/tb_tilelink_n_to_1.sv
// Bench for tilelink_n_to_1: directed A sequences, D routing table (TLM=2 and TLM=3), randomized A vs. reference model.
module tb_tilelink_n_to_1;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;

  // TLM=2 instance
  logic [5:0] a_aop, a_apar; logic [7:0] a_asz; logic [3:0] a_asrc; logic [63:0] a_aadr;
  logic [7:0] a_amsk; logic [63:0] a_adat; logic [1:0] a_acor, a_avld, a_ardy;
  logic [5:0] a_dop; logic [3:0] a_dpar; logic [7:0] a_dsz; logic [3:0] a_dsrc;
  logic [1:0] a_dden, a_dcor, a_dvld, a_drdy; logic [63:0] a_ddat;
  logic [2:0] s_aop, s_apar; logic [3:0] s_asz; logic [2:0] s_asrc; logic [31:0] s_aadr;
  logic [3:0] s_amsk; logic [31:0] s_adat; logic s_acor, s_avld, s_ardy;
  logic [2:0] s_dop; logic [1:0] s_dpar; logic [3:0] s_dsz; logic [2:0] s_dsrc;
  logic s_dden, s_dcor, s_dvld, s_drdy; logic [31:0] s_ddat;

  // TLM=3 instance
  logic [8:0] b_aop, b_apar; logic [11:0] b_asz; logic [5:0] b_asrc; logic [95:0] b_aadr;
  logic [11:0] b_amsk; logic [95:0] b_adat; logic [2:0] b_acor, b_avld, b_ardy;
  logic [8:0] b_dop; logic [5:0] b_dpar; logic [11:0] b_dsz; logic [5:0] b_dsrc;
  logic [2:0] b_dden, b_dcor, b_dvld, b_drdy; logic [95:0] b_ddat;
  logic [2:0] u_aop, u_apar; logic [3:0] u_asz; logic [3:0] u_asrc; logic [31:0] u_aadr;
  logic [3:0] u_amsk; logic [31:0] u_adat; logic u_acor, u_avld, u_ardy;
  logic [2:0] u_dop; logic [1:0] u_dpar; logic [3:0] u_dsz; logic [3:0] u_dsrc;
  logic u_dden, u_dcor, u_dvld, u_drdy; logic [31:0] u_ddat;

  tilelink_n_to_1 #(.TLM(2)) dut (
    .tilelink_clock_i(clk), .tilelink_reset_i(rst),
    .master_a_opcode(a_aop), .master_a_param(a_apar), .master_a_size(a_asz),
    .master_a_source(a_asrc), .master_a_address(a_aadr), .master_a_mask(a_amsk),
    .master_a_data(a_adat), .master_a_corrupt(a_acor), .master_a_valid(a_avld),
    .master_a_ready(a_ardy),
    .master_d_opcode(a_dop), .master_d_param(a_dpar), .master_d_size(a_dsz),
    .master_d_source(a_dsrc), .master_d_denied(a_dden), .master_d_corrupt(a_dcor),
    .master_d_valid(a_dvld), .master_d_data(a_ddat), .master_d_ready(a_drdy),
    .slave_a_opcode(s_aop), .slave_a_param(s_apar), .slave_a_size(s_asz),
    .slave_a_source(s_asrc), .slave_a_address(s_aadr), .slave_a_mask(s_amsk),
    .slave_a_data(s_adat), .slave_a_corrupt(s_acor), .slave_a_valid(s_avld),
    .slave_a_ready(s_ardy),
    .slave_d_opcode(s_dop), .slave_d_param(s_dpar), .slave_d_size(s_dsz),
    .slave_d_source(s_dsrc), .slave_d_denied(s_dden), .slave_d_corrupt(s_dcor),
    .slave_d_valid(s_dvld), .slave_d_data(s_ddat), .slave_d_ready(s_drdy));

  tilelink_n_to_1 #(.TLM(3)) dut3 (
    .tilelink_clock_i(clk), .tilelink_reset_i(rst),
    .master_a_opcode(b_aop), .master_a_param(b_apar), .master_a_size(b_asz),
    .master_a_source(b_asrc), .master_a_address(b_aadr), .master_a_mask(b_amsk),
    .master_a_data(b_adat), .master_a_corrupt(b_acor), .master_a_valid(b_avld),
    .master_a_ready(b_ardy),
    .master_d_opcode(b_dop), .master_d_param(b_dpar), .master_d_size(b_dsz),
    .master_d_source(b_dsrc), .master_d_denied(b_dden), .master_d_corrupt(b_dcor),
    .master_d_valid(b_dvld), .master_d_data(b_ddat), .master_d_ready(b_drdy),
    .slave_a_opcode(u_aop), .slave_a_param(u_apar), .slave_a_size(u_asz),
    .slave_a_source(u_asrc), .slave_a_address(u_aadr), .slave_a_mask(u_amsk),
    .slave_a_data(u_adat), .slave_a_corrupt(u_acor), .slave_a_valid(u_avld),
    .slave_a_ready(u_ardy),
    .slave_d_opcode(u_dop), .slave_d_param(u_dpar), .slave_d_size(u_dsz),
    .slave_d_source(u_dsrc), .slave_d_denied(u_dden), .slave_d_corrupt(u_dcor),
    .slave_d_valid(u_dvld), .slave_d_data(u_ddat), .slave_d_ready(u_drdy));

  // per-master A beat currently presented on the TLM=2 instance
  logic [2:0] t_op[2], t_par[2]; logic [3:0] t_sz[2], t_msk[2]; logic [1:0] t_src[2];
  logic [31:0] t_adr[2], t_dat[2]; logic t_cor[2], t_vld[2];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_a();
    for (int i = 0; i < 2; i++) begin
      a_aop[i*3 +: 3] = t_op[i];   a_apar[i*3 +: 3] = t_par[i];
      a_asz[i*4 +: 4] = t_sz[i];   a_asrc[i*2 +: 2] = t_src[i];
      a_aadr[i*32 +: 32] = t_adr[i]; a_amsk[i*4 +: 4] = t_msk[i];
      a_adat[i*32 +: 32] = t_dat[i]; a_acor[i] = t_cor[i]; a_avld[i] = t_vld[i];
    end
  endtask

  task automatic set_beat(input int i, input logic [2:0] op, input logic [3:0] sz,
                          input logic [1:0] src, input logic [31:0] adr, input logic [31:0] dat,
                          input logic v);
    t_op[i] = op; t_par[i] = 3'd0; t_sz[i] = sz; t_src[i] = src; t_adr[i] = adr;
    t_msk[i] = 4'hF; t_dat[i] = dat; t_cor[i] = 1'b0; t_vld[i] = v;
    drive_a();
  endtask

  // Beats per transaction for 32-bit data (TL_DW=5, so size above 2 spans several beats).
  function automatic int beats_of(input logic [2:0] op, input logic [3:0] sz);
    return (op <= 3'd1 && sz > 4'd2) ? (1 << (sz - 4'd2)) : 1;
  endfunction

  typedef struct {
    bit         sel3;
    logic [3:0] src;
    logic       vld;
    logic [2:0] mrdy;
    logic [2:0] e_mvld;
    logic       e_srdy;
  } drow_t;

  drow_t dtab[11];

  initial begin
    dtab[0]  = '{0, 4'b0110, 1, 3'b000, 3'b010, 0};
    dtab[1]  = '{0, 4'b0110, 1, 3'b000, 3'b010, 0};
    dtab[2]  = '{0, 4'b0110, 1, 3'b010, 3'b010, 1};
    dtab[3]  = '{0, 4'b0001, 1, 3'b010, 3'b001, 0};
    dtab[4]  = '{0, 4'b0001, 1, 3'b001, 3'b001, 1};
    dtab[5]  = '{0, 4'b0101, 0, 3'b001, 3'b000, 0};
    dtab[6]  = '{1, 4'b1110, 1, 3'b000, 3'b000, 1};
    dtab[7]  = '{1, 4'b1001, 1, 3'b100, 3'b100, 1};
    dtab[8]  = '{1, 4'b1001, 1, 3'b011, 3'b100, 0};
    dtab[9]  = '{1, 4'b0110, 1, 3'b010, 3'b010, 1};
    dtab[10] = '{1, 4'b1111, 0, 3'b000, 3'b000, 1};

    b_aop = '0; b_apar = '0; b_asz = '0; b_asrc = '0; b_aadr = '0; b_amsk = '0;
    b_adat = '0; b_acor = '0; b_avld = '0; b_drdy = '0; u_ardy = 1'b1;
    u_dop = '0; u_dpar = '0; u_dsz = '0; u_dsrc = '0; u_dden = 0; u_dcor = 0; u_dvld = 0; u_ddat = '0;
    s_dop = '0; s_dpar = '0; s_dsz = '0; s_dsrc = '0; s_dden = 0; s_dcor = 0; s_dvld = 0; s_ddat = '0;
    a_drdy = '0; s_ardy = 1'b1;

    // reset state, with masters requesting to prove ready is held off
    set_beat(0, 3'd4, 4'd2, 2'b01, 32'h1111_0000, 32'h0, 1'b1);
    set_beat(1, 3'd4, 4'd2, 2'b10, 32'h2222_0000, 32'h0, 1'b1);
    #1;
    chk("rst_avld", s_avld, 0); chk("rst_ardy", a_ardy, 0);
    chk("rst_src", s_asrc, 0);  chk("rst_adr", s_aadr, 0);
    @(negedge clk); rst = 1'b0; t_vld[0] = 0; t_vld[1] = 0; drive_a();

    // two simultaneous Gets: master 0 then master 1, pointer back at 0
    @(negedge clk);
    set_beat(0, 3'd4, 4'd2, 2'b01, 32'hA000_0000, 32'h0, 1'b1);
    set_beat(1, 3'd4, 4'd2, 2'b11, 32'hA100_0000, 32'h0, 1'b1);
    #1 chk("s1_rdy0", a_ardy, 2'b01);
    @(negedge clk); t_vld[0] = 0; drive_a();
    #1 chk("s1_src0", s_asrc, 3'b001); chk("s1_adr0", s_aadr, 32'hA000_0000);
    chk("s1_vld0", s_avld, 1); chk("s1_rdy1", a_ardy, 2'b10);
    @(negedge clk); t_vld[1] = 0; drive_a();
    #1 chk("s1_src1", s_asrc, 3'b111); chk("s1_adr1", s_aadr, 32'hA100_0000);
    @(negedge clk);
    #1 chk("s1_idle", s_avld, 0);
    set_beat(0, 3'd4, 4'd2, 2'b00, 32'hB000_0000, 32'h0, 1'b1);
    set_beat(1, 3'd4, 4'd2, 2'b00, 32'hB100_0000, 32'h0, 1'b1);
    #1 chk("s1_ptr0", a_ardy, 2'b01);

    // 4-beat PutFullData from master 1 while master 0 keeps requesting
    @(negedge clk);
    set_beat(0, 3'd4, 4'd2, 2'b10, 32'hC000_0000, 32'h0, 1'b1);
    set_beat(1, 3'd0, 4'd4, 2'b01, 32'hD000_0000, 32'hDA7A_0000, 1'b1);
    #1 chk("s2_rdy_first", a_ardy, 2'b10);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      chk("s2_dat", s_adat, 32'hDA7A_0000 + 32'(b));
      chk("s2_src", s_asrc, 3'b101);
      chk("s2_op", s_aop, 3'd0);
      if (b < 3) t_dat[1] = 32'hDA7A_0000 + 32'(b + 1);
      else       t_vld[1] = 1'b0;
      drive_a();
      #1 chk("s2_rdy", a_ardy, (b < 3) ? 2'b10 : 2'b01);
    end
    @(negedge clk);
    chk("s2_m0_src", s_asrc, 3'b010); chk("s2_m0_adr", s_aadr, 32'hC000_0000);

    // slave backpressure for 3 cycles
    s_ardy = 1'b0; t_vld[0] = 1'b0;
    set_beat(1, 3'd4, 4'd2, 2'b10, 32'hE100_0000, 32'h0, 1'b1);
    #1 chk("s3_rdy_hold", a_ardy, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1 chk("s3_vld", s_avld, 1); chk("s3_adr", s_aadr, 32'hC000_0000);
      chk("s3_src", s_asrc, 3'b010); chk("s3_rdy", a_ardy, 0);
    end
    s_ardy = 1'b1;
    #1 chk("s3_rdy_rel", a_ardy, 2'b10);
    @(negedge clk); t_vld[1] = 1'b0; drive_a();
    #1 chk("s3_src1", s_asrc, 3'b110); chk("s3_adr1", s_aadr, 32'hE100_0000);
    @(negedge clk);
    #1 chk("s3_nodup", s_avld, 0);

    // async reset during beat 2 of a 4-beat burst from master 1
    set_beat(1, 3'd0, 4'd4, 2'b00, 32'hF100_0000, 32'h5000_0000, 1'b1);
    #1 chk("s5_rdy_b0", a_ardy, 2'b10);
    @(negedge clk); t_dat[1] = 32'h5000_0001; drive_a();
    @(negedge clk);
    chk("s5_beat2", s_adat, 32'h5000_0001);
    #2 rst = 1'b1;
    #1 chk("s5_async_vld", s_avld, 0); chk("s5_async_rdy", a_ardy, 0);
    @(negedge clk); rst = 1'b0;
    set_beat(0, 3'd4, 4'd2, 2'b00, 32'h9000_0000, 32'h0, 1'b1);
    #1 chk("s5_after_rst", a_ardy, 2'b01);
    @(negedge clk); t_vld[0] = 0; t_vld[1] = 0; drive_a();

    // D routing table
    for (int r = 0; r < 11; r++) begin
      @(negedge clk);
      if (!dtab[r].sel3) begin
        s_dsrc = dtab[r].src[2:0]; s_dvld = dtab[r].vld; a_drdy = dtab[r].mrdy[1:0];
        s_ddat = $urandom;
        #1;
        chk("d2_mvld", a_dvld, dtab[r].e_mvld[1:0]);
        chk("d2_srdy", s_drdy, dtab[r].e_srdy);
        chk("d2_msrc", a_dsrc, {2{dtab[r].src[1:0]}});
        chk("d2_data", a_ddat, {2{s_ddat}});
      end else begin
        u_dsrc = dtab[r].src; u_dvld = dtab[r].vld; b_drdy = dtab[r].mrdy;
        #1;
        chk("d3_mvld", b_dvld, dtab[r].e_mvld);
        chk("d3_srdy", u_drdy, dtab[r].e_srdy);
        chk("d3_msrc", b_dsrc, {3{dtab[r].src[1:0]}});
      end
    end
    s_dvld = 0; u_dvld = 0;

    // randomized A traffic against a reference model
    begin
      bit pend[2]; int rem[2];
      int m_ptr, m_left, m_mst, g;
      bit e_val, ld;
      logic [34:0] e_sa; logic [46:0] e_pl; logic [1:0] e_rdy;
      logic [2:0] ops[3];
      ops[0] = 3'd0; ops[1] = 3'd1; ops[2] = 3'd4;
      rst = 1'b1; t_vld[0] = 0; t_vld[1] = 0; drive_a();
      @(negedge clk); rst = 1'b0;
      pend[0] = 0; pend[1] = 0; rem[0] = 0; rem[1] = 0;
      m_ptr = 0; m_left = 0; m_mst = 0; e_val = 0; e_sa = '0; e_pl = '0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
        @(negedge clk);
        s_ardy = ($urandom_range(0, 3) != 0);
        for (int i = 0; i < 2; i++) begin
          if (!pend[i]) begin
            if (rem[i] > 0) begin
              if ($urandom_range(0, 3) != 0) begin
                t_dat[i] = $urandom; t_msk[i] = 4'($urandom); t_cor[i] = 1'($urandom);
                rem[i]--; pend[i] = 1;
              end
            end else if ($urandom_range(0, 1) == 1) begin
              t_op[i] = ops[$urandom_range(0, 2)]; t_sz[i] = 4'($urandom_range(0, 5));
              t_par[i] = 3'($urandom); t_src[i] = 2'($urandom); t_adr[i] = $urandom;
              t_dat[i] = $urandom; t_msk[i] = 4'($urandom); t_cor[i] = 1'($urandom);
              rem[i] = beats_of(t_op[i], t_sz[i]) - 1; pend[i] = 1;
            end
          end
          t_vld[i] = pend[i];
        end
        drive_a();
        #1;
        ld = !e_val || s_ardy;
        g = -1;
        if (m_left > 0) begin
          if (pend[m_mst]) g = m_mst;
        end else begin
          for (int k = 0; k < 2; k++)
            if (g < 0 && pend[(m_ptr + k) % 2]) g = (m_ptr + k) % 2;
        end
        e_rdy = (ld && g >= 0) ? (2'b01 << g) : 2'b00;
        chk("rnd_ardy", a_ardy, e_rdy);
        chk("rnd_avld", s_avld, e_val);
        if (e_val) begin
          chk("rnd_src_adr", {s_asrc, s_aadr}, e_sa);
          chk("rnd_payload", {s_aop, s_apar, s_asz, s_amsk, s_adat, s_acor}, e_pl);
        end
        if (ld) begin
          if (g >= 0) begin
            e_val = 1;
            e_sa = {g[0], t_src[g], t_adr[g]};
            e_pl = {t_op[g], t_par[g], t_sz[g], t_msk[g], t_dat[g], t_cor[g]};
            pend[g] = 0;
            if (m_left == 0) begin
              if (beats_of(t_op[g], t_sz[g]) > 1) begin
                m_left = beats_of(t_op[g], t_sz[g]) - 1; m_mst = g;
              end else m_ptr = (g + 1) % 2;
            end else begin
              m_left--;
              if (m_left == 0) m_ptr = (g + 1) % 2;
            end
          end else e_val = 0;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
